// File: rtl/reaction_pkg.sv
// Shared types, mode codes and helpers for the reaction round controller.
package reaction_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StArm,
      StRun,
      StDone
   } state_e;

   localparam logic [2:0] ModeIdle   = 3'd0;
   localparam logic [2:0] ModeRun    = 3'd1;
   localparam logic [2:0] ModeDone   = 3'd2;
   localparam logic [2:0] ModeWinner = 3'd4;
   localparam logic [2:0] ModeBest   = 3'd5;
   localparam logic [2:0] ModePlayer = 3'd6;

   // Largest value a counter of the given width can hold.
   function automatic logic [31:0] cnt_max(input int unsigned width);
      if (width >= 32) begin
         return 32'hFFFF_FFFF;
      end
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/reaction_min_select.sv
// Combinational argmin over N packed values with a valid mask; ties go to the lowest index.
module reaction_min_select #(
   parameter int unsigned N     = 2,
   parameter int unsigned W     = 10,
   parameter int unsigned IDX_W = 1
) (
   input  logic [N*W-1:0] values,
   input  logic [N-1:0]   valid,
   output logic [IDX_W-1:0] idx,
   output logic [W-1:0]   value,
   output logic           any_valid
);

   // Strict less-than keeps the earliest index on ties.
   always_comb begin
      idx       = '0;
      value     = '1;
      any_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (valid[i] && (!any_valid || (values[i*W +: W] < value))) begin
            idx       = IDX_W'(i);
            value     = values[i*W +: W];
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reaction_round_ctrl.sv
// N-player reaction round controller: round FSM, per-player scores and history,
// winner/best selection and a registered display mux.
module reaction_round_ctrl
   import reaction_pkg::*;
#(
   parameter int unsigned N_PLAYERS = 2,
   parameter int unsigned CNT_W     = 10,
   parameter int unsigned HIST_W    = 5,
   parameter int unsigned IDX_W     = $clog2(N_PLAYERS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start_btn,
   input  logic [N_PLAYERS-1:0]        stop_btn,
   input  logic                        q_winner,
   input  logic                        q_best,
   input  logic                        q_player,
   input  logic [IDX_W-1:0]            q_idx,
   input  logic [CNT_W-1:0]            counter,
   output logic                        cnt_clr,
   output logic                        cnt_en,
   output logic [2:0]                  mode,
   output logic [N_PLAYERS-1:0]        stop_mask,
   output logic [N_PLAYERS*CNT_W-1:0]  score,
   output logic [N_PLAYERS*HIST_W-1:0] rounds,
   output logic [N_PLAYERS-1:0]        timeout,
   output logic [IDX_W-1:0]            winner_id,
   output logic                        winner_valid,
   output logic [CNT_W-1:0]            best,
   output logic [IDX_W-1:0]            best_id,
   output logic                        best_valid,
   output logic [CNT_W-1:0]            disp_value,
   output logic [IDX_W-1:0]            disp_id
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_max(CNT_W));

   state_e               state_q;
   logic                 eval_q;
   logic                 run;
   logic                 hit_to;
   logic [CNT_W-1:0]     stop_val;
   logic [N_PLAYERS-1:0] stop_hit;
   logic [N_PLAYERS-1:0] mask_next;
   logic                 round_end;
   logic                 q_any;
   logic [2:0]           q_mode;
   logic [N_PLAYERS-1:0] sel_mask;
   logic [IDX_W-1:0]     sel_idx;
   logic [CNT_W-1:0]     sel_val;
   logic                 sel_valid;
   logic [CNT_W-1:0]     win_score;
   logic [CNT_W-1:0]     player_score;

   assign run       = (state_q == StRun);
   assign hit_to    = run && (counter == CntMax);
   assign stop_val  = (counter == CntMax) ? CntMax : counter + 1'b1;
   assign stop_hit  = run ? (stop_btn & ~stop_mask) : '0;
   assign mask_next = stop_mask | stop_hit | (hit_to ? {N_PLAYERS{1'b1}} : '0);
   assign round_end = run && (&mask_next);
   assign q_any     = q_winner | q_best | q_player;
   assign q_mode    = q_winner ? ModeWinner : (q_best ? ModeBest : ModePlayer);
   assign sel_mask  = ~timeout;

   reaction_min_select #(
      .N     (N_PLAYERS),
      .W     (CNT_W),
      .IDX_W (IDX_W)
   ) u_min_select (
      .values    (score),
      .valid     (sel_mask),
      .idx       (sel_idx),
      .value     (sel_val),
      .any_valid (sel_valid)
   );

   // Score lookups for the display mux; unmatched indices read as all-ones.
   always_comb begin
      win_score    = '1;
      player_score = '1;
      for (int i = 0; i < N_PLAYERS; i++) begin
         if (winner_id == IDX_W'(i)) begin
            win_score = score[i*CNT_W +: CNT_W];
         end
         if (q_idx == IDX_W'(i)) begin
            player_score = score[i*CNT_W +: CNT_W];
         end
      end
   end

   // Round FSM with registered counter controls and mode code.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         mode    <= ModeIdle;
         cnt_clr <= 1'b0;
         cnt_en  <= 1'b0;
         eval_q  <= 1'b0;
      end else begin
         cnt_clr <= 1'b0;
         eval_q  <= 1'b0;
         case (state_q)
            StIdle, StDone: begin
               if (start_btn) begin
                  state_q <= StArm;
                  cnt_clr <= 1'b1;
                  mode    <= ModeRun;
               end else if (q_any) begin
                  mode <= q_mode;
               end
            end
            StArm: begin
               state_q <= StRun;
               cnt_en  <= 1'b1;
               mode    <= ModeRun;
            end
            StRun: begin
               if (round_end) begin
                  state_q <= StDone;
                  cnt_en  <= 1'b0;
                  mode    <= ModeDone;
                  eval_q  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Per-player stop capture, timeout, history and winner/best update.
   always_ff @(posedge clk) begin
      if (rst) begin
         stop_mask    <= '0;
         score        <= '0;
         rounds       <= '0;
         timeout      <= '0;
         winner_id    <= '0;
         winner_valid <= 1'b0;
         best         <= '1;
         best_id      <= '0;
         best_valid   <= 1'b0;
      end else begin
         if (state_q == StArm) begin
            stop_mask    <= '0;
            timeout      <= '0;
            winner_valid <= 1'b0;
         end else if (run) begin
            stop_mask <= mask_next;
            for (int i = 0; i < N_PLAYERS; i++) begin
               if (stop_hit[i]) begin
                  score[i*CNT_W +: CNT_W] <= stop_val;
                  if (!(&rounds[i*HIST_W +: HIST_W])) begin
                     rounds[i*HIST_W +: HIST_W] <= rounds[i*HIST_W +: HIST_W] + 1'b1;
                  end
               end else if (hit_to && !stop_mask[i]) begin
                  score[i*CNT_W +: CNT_W] <= CntMax;
                  timeout[i]              <= 1'b1;
               end
            end
         end
         // Scores are settled one cycle after entering DONE.
         if (eval_q && sel_valid) begin
            winner_id    <= sel_idx;
            winner_valid <= 1'b1;
            if (sel_val < best) begin
               best       <= sel_val;
               best_id    <= sel_idx;
               best_valid <= 1'b1;
            end
         end
      end
   end

   // Registered display mux, priority winner > best > player.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_value <= '1;
         disp_id    <= '0;
      end else if (q_winner) begin
         disp_value <= winner_valid ? win_score : '1;
         disp_id    <= winner_id;
      end else if (q_best) begin
         disp_value <= best;
         disp_id    <= best_id;
      end else if (q_player) begin
         disp_value <= player_score;
         disp_id    <= q_idx;
      end
   end

endmodule
